// File: rtl/status_event_bank_if.sv
// Processor register bus for status_event_bank: select, read/write strobes,
// register index, write data and registered read data.
interface status_event_bank_if #(
   parameter int NUM_CHANNELS = 4,
   parameter int DATA_WIDTH   = 32
);
   localparam int ADDR_WIDTH = $clog2(NUM_CHANNELS + 2);

   logic                  Sys_RegSelect;
   logic                  Sys_RdEn;
   logic                  Sys_WrEn;
   logic [ADDR_WIDTH-1:0] Sys_Addr;
   logic [DATA_WIDTH-1:0] Sys_WrData;
   logic [DATA_WIDTH-1:0] Sys_RdData;

   modport master (
      output Sys_RegSelect, Sys_RdEn, Sys_WrEn, Sys_Addr, Sys_WrData,
      input  Sys_RdData
   );

   modport slave (
      input  Sys_RegSelect, Sys_RdEn, Sys_WrEn, Sys_Addr, Sys_WrData,
      output Sys_RdData
   );
endinterface

// File: rtl/status_event_bank.sv
// Multi-channel event status block: saturating per-channel counters with
// overflow flags, sticky W1C status word, interrupt enable and registered Irq.
module status_event_bank #(
   parameter int                    NUM_CHANNELS = 4,
   parameter int                    COUNT_WIDTH  = 8,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [NUM_CHANNELS-1:0] CLEAR_MASK = '1
) (
   input  logic                    Clock,
   input  logic                    Reset,
   status_event_bank_if.slave      sys,
   input  logic [NUM_CHANNELS-1:0] Evt_Pulse,
   output logic                    Irq
);
   localparam int ADDR_WIDTH = $clog2(NUM_CHANNELS + 2);
   localparam logic [ADDR_WIDTH-1:0] STATUS_IDX = ADDR_WIDTH'(NUM_CHANNELS);
   localparam logic [ADDR_WIDTH-1:0] IEN_IDX    = ADDR_WIDTH'(NUM_CHANNELS + 1);

   logic [COUNT_WIDTH-1:0]  cnt_q [NUM_CHANNELS];
   logic [COUNT_WIDTH-1:0]  cnt_d [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] ovf_q, ovf_d;
   logic [NUM_CHANNELS-1:0] stat_q, stat_d;
   logic [NUM_CHANNELS-1:0] ien_q, ien_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    irq_q, irq_d;

   logic                    rd_fire, wr_fire;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [NUM_CHANNELS-1:0] w1c;
   logic [COUNT_WIDTH-1:0]  base;
   logic                    clr;

   // A write wins over a simultaneous read: the read neither clears nor returns data.
   assign rd_fire = sys.Sys_RegSelect & sys.Sys_RdEn & ~sys.Sys_WrEn;
   assign wr_fire = sys.Sys_RegSelect & sys.Sys_WrEn;

   always_comb begin
      rd_word = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (sys.Sys_Addr == ADDR_WIDTH'(c)) begin
            rd_word[COUNT_WIDTH-1:0] = cnt_q[c];
            rd_word[DATA_WIDTH-1]    = ovf_q[c];
         end
      end
      if (sys.Sys_Addr == STATUS_IDX) rd_word[NUM_CHANNELS-1:0] = stat_q;
      if (sys.Sys_Addr == IEN_IDX)    rd_word[NUM_CHANNELS-1:0] = ien_q;
   end

   always_comb begin
      base  = '0;
      clr   = 1'b0;
      ovf_d = ovf_q;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         cnt_d[c] = cnt_q[c];
         clr      = rd_fire && (sys.Sys_Addr == ADDR_WIDTH'(c)) && CLEAR_MASK[c];
         base     = clr ? '0 : cnt_q[c];
         ovf_d[c] = clr ? 1'b0 : ovf_q[c];
         if (Evt_Pulse[c]) begin
            if (base != {COUNT_WIDTH{1'b1}}) cnt_d[c] = base + 1'b1;
            else begin
               cnt_d[c] = base;
               ovf_d[c] = 1'b1;
            end
         end else begin
            cnt_d[c] = base;
         end
      end
   end

   always_comb begin
      w1c     = (wr_fire && sys.Sys_Addr == STATUS_IDX) ? sys.Sys_WrData[NUM_CHANNELS-1:0] : '0;
      stat_d  = (stat_q & ~w1c) | Evt_Pulse;
      ien_d   = (wr_fire && sys.Sys_Addr == IEN_IDX) ? sys.Sys_WrData[NUM_CHANNELS-1:0] : ien_q;
      rdata_d = rd_fire ? rd_word : rdata_q;
      irq_d   = |(stat_d & ien_d);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cnt_q   <= '{default: '0};
         ovf_q   <= '0;
         stat_q  <= '0;
         ien_q   <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         stat_q  <= stat_d;
         ien_q   <= ien_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

   assign sys.Sys_RdData = rdata_q;
   assign Irq            = irq_q;
endmodule

// File: tb/tb_status_event_bank.sv
// Bench for status_event_bank: two instances (4-bit counters with full clear
// mask, 8-bit counters with mask 1110) share stimulus and a behavioural model.
module tb_status_event_bank;
   logic        clk;
   logic        rst_n;
   logic        sel, rd, wr;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  evt;
   logic [31:0] rdo_a, rdo_b;
   logic        irq_a, irq_b;

   int total = 0;
   int bad   = 0;

   status_event_bank_if #(.NUM_CHANNELS(4), .DATA_WIDTH(32)) bus_a ();
   status_event_bank_if #(.NUM_CHANNELS(4), .DATA_WIDTH(32)) bus_b ();

   assign bus_a.Sys_RegSelect = sel;
   assign bus_a.Sys_RdEn      = rd;
   assign bus_a.Sys_WrEn      = wr;
   assign bus_a.Sys_Addr      = addr;
   assign bus_a.Sys_WrData    = wdata;
   assign bus_b.Sys_RegSelect = sel;
   assign bus_b.Sys_RdEn      = rd;
   assign bus_b.Sys_WrEn      = wr;
   assign bus_b.Sys_Addr      = addr;
   assign bus_b.Sys_WrData    = wdata;
   assign rdo_a = bus_a.Sys_RdData;
   assign rdo_b = bus_b.Sys_RdData;

   status_event_bank #(.NUM_CHANNELS(4), .COUNT_WIDTH(4), .DATA_WIDTH(32), .CLEAR_MASK(4'b1111))
      dut_a (.Clock(clk), .Reset(rst_n), .sys(bus_a), .Evt_Pulse(evt), .Irq(irq_a));
   status_event_bank #(.NUM_CHANNELS(4), .COUNT_WIDTH(8), .DATA_WIDTH(32), .CLEAR_MASK(4'b1110))
      dut_b (.Clock(clk), .Reset(rst_n), .sys(bus_b), .Evt_Pulse(evt), .Irq(irq_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Reference model: index 0 is dut_a, index 1 is dut_b.
   int          cmax  [2] = '{15, 255};
   logic [3:0]  cmask [2] = '{4'b1111, 4'b1110};
   int          m_cnt [2][4];
   bit          m_ovf [2][4];
   logic [3:0]  m_stat[2];
   logic [3:0]  m_ien [2];
   logic [31:0] m_rd  [2];
   logic        m_irq [2];
   bit          m_rdf, m_wrf, m_clr;
   int          m_base;
   logic [3:0]  m_w1c;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
               m_cnt[d][c] = 0;
               m_ovf[d][c] = 0;
            end
            m_stat[d] = '0; m_ien[d] = '0; m_rd[d] = '0; m_irq[d] = 1'b0;
         end
      end else begin
         m_rdf = sel && rd && !wr;
         m_wrf = sel && wr;
         for (int d = 0; d < 2; d++) begin
            if (m_rdf) begin
               if (addr < 4)       m_rd[d] = (m_ovf[d][addr] ? 32'h8000_0000 : 32'h0) + 32'(m_cnt[d][addr]);
               else if (addr == 4) m_rd[d] = {28'h0, m_stat[d]};
               else if (addr == 5) m_rd[d] = {28'h0, m_ien[d]};
               else                m_rd[d] = 32'h0;
            end
            for (int c = 0; c < 4; c++) begin
               m_clr  = m_rdf && (addr == c) && cmask[d][c];
               m_base = m_clr ? 0 : m_cnt[d][c];
               if (m_clr) m_ovf[d][c] = 0;
               if (evt[c]) begin
                  if (m_base < cmax[d]) m_base = m_base + 1;
                  else                  m_ovf[d][c] = 1;
               end
               m_cnt[d][c] = m_base;
            end
            m_w1c     = (m_wrf && addr == 4) ? wdata[3:0] : 4'h0;
            m_stat[d] = (m_stat[d] & ~m_w1c) | evt;
            if (m_wrf && addr == 5) m_ien[d] = wdata[3:0];
            m_irq[d] = |(m_stat[d] & m_ien[d]);
         end
      end
   end

   task automatic step(input logic s, input logic r, input logic w, input logic [2:0] a,
                       input logic [31:0] wd, input logic [3:0] e);
      sel = s; rd = r; wr = w; addr = a; wdata = wd; evt = e;
      @(posedge clk); #1;
      sel = 1'b0; rd = 1'b0; wr = 1'b0; evt = 4'h0;
   endtask

   task automatic pulse(input int ch, input int n);
      repeat (n) step(0, 0, 0, 3'd0, 32'h0, 4'(1 << ch));
   endtask

   task automatic rd_idx(input logic [2:0] a);
      step(1, 1, 0, a, 32'h0, 4'h0);
   endtask

   task automatic wr_idx(input logic [2:0] a, input logic [31:0] d);
      step(1, 0, 1, a, d, 4'h0);
   endtask

   task automatic do_reset();
      sel = 0; rd = 0; wr = 0; addr = 0; wdata = 0; evt = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (irq_a !== 1'b0 || irq_b !== 1'b0) begin
         bad++; $display("FAIL reset_irq a=%b b=%b exp=0", irq_a, irq_b);
      end
      for (int i = 0; i < 8; i++) begin
         rd_idx(3'(i));
         total++;
         if (rdo_a !== 32'h0 || rdo_b !== 32'h0 || irq_a !== 1'b0 || irq_b !== 1'b0) begin
            bad++; $display("FAIL reset_read idx=%0d a=%h b=%h irq=%b%b exp=0", i, rdo_a, rdo_b, irq_a, irq_b);
         end
      end
   endtask

   task automatic test_count();
      pulse(1, 5);
      rd_idx(3'd1);
      total++;
      if (rdo_a !== 32'd5 || rdo_b !== 32'd5) begin
         bad++; $display("FAIL count5 a=%h b=%h exp=5", rdo_a, rdo_b);
      end
      rd_idx(3'd4);
      total++;
      if (rdo_a !== 32'h2 || rdo_b !== 32'h2) begin
         bad++; $display("FAIL status_bit1 a=%h b=%h exp=2", rdo_a, rdo_b);
      end
      rd_idx(3'd1);
      total++;
      if (rdo_a !== 32'h0 || rdo_b !== 32'h0) begin
         bad++; $display("FAIL count_cleared a=%h b=%h exp=0", rdo_a, rdo_b);
      end
   endtask

   task automatic test_saturate();
      pulse(0, 17);
      rd_idx(3'd0);
      total++;
      if (rdo_a !== 32'h8000_000F || rdo_b !== 32'h11) begin
         bad++; $display("FAIL saturate a=%h exp=8000000f b=%h exp=11", rdo_a, rdo_b);
      end
      rd_idx(3'd0);
      total++;
      if (rdo_a !== 32'h0 || rdo_b !== 32'h11) begin
         bad++; $display("FAIL after_saturate a=%h exp=0 b=%h exp=11", rdo_a, rdo_b);
      end
   endtask

   task automatic test_event_in_read();
      pulse(2, 3);
      step(1, 1, 0, 3'd2, 32'h0, 4'b0100);
      total++;
      if (rdo_a !== 32'd3 || rdo_b !== 32'd3) begin
         bad++; $display("FAIL read_with_evt a=%h b=%h exp=3", rdo_a, rdo_b);
      end
      rd_idx(3'd2);
      total++;
      if (rdo_a !== 32'd1 || rdo_b !== 32'd1) begin
         bad++; $display("FAIL evt_after_clear a=%h b=%h exp=1", rdo_a, rdo_b);
      end
   endtask

   task automatic test_irq();
      wr_idx(3'd4, 32'hF);
      wr_idx(3'd5, 32'h4);
      total++;
      if (irq_a !== 1'b0 || irq_b !== 1'b0) begin
         bad++; $display("FAIL irq_idle a=%b b=%b exp=0", irq_a, irq_b);
      end
      pulse(2, 1);
      total++;
      if (irq_a !== 1'b1 || irq_b !== 1'b1) begin
         bad++; $display("FAIL irq_rise a=%b b=%b exp=1", irq_a, irq_b);
      end
      step(1, 0, 1, 3'd4, 32'h4, 4'b0100);
      total++;
      if (irq_a !== 1'b1 || irq_b !== 1'b1) begin
         bad++; $display("FAIL irq_set_wins a=%b b=%b exp=1", irq_a, irq_b);
      end
      rd_idx(3'd4);
      total++;
      if (rdo_a !== 32'h4 || rdo_b !== 32'h4) begin
         bad++; $display("FAIL status_set_wins a=%h b=%h exp=4", rdo_a, rdo_b);
      end
      wr_idx(3'd4, 32'h4);
      total++;
      if (irq_a !== 1'b0 || irq_b !== 1'b0) begin
         bad++; $display("FAIL irq_fall_w1c a=%b b=%b exp=0", irq_a, irq_b);
      end
      pulse(1, 1);
      wr_idx(3'd5, 32'h6);
      total++;
      if (irq_a !== 1'b1 || irq_b !== 1'b1) begin
         bad++; $display("FAIL irq_rise_enable a=%b b=%b exp=1", irq_a, irq_b);
      end
      wr_idx(3'd5, 32'h0);
      total++;
      if (irq_a !== 1'b0 || irq_b !== 1'b0) begin
         bad++; $display("FAIL irq_fall_enable a=%b b=%b exp=0", irq_a, irq_b);
      end
   endtask

   task automatic test_rw_collision();
      wr_idx(3'd5, 32'h9);
      rd_idx(3'd5);
      total++;
      if (rdo_a !== 32'h9 || rdo_b !== 32'h9) begin
         bad++; $display("FAIL ien_read a=%h b=%h exp=9", rdo_a, rdo_b);
      end
      pulse(3, 2);
      step(1, 1, 1, 3'd3, 32'hFFFF_FFFF, 4'h0);
      total++;
      if (rdo_a !== 32'h9 || rdo_b !== 32'h9) begin
         bad++; $display("FAIL rw_hold a=%h b=%h exp=9", rdo_a, rdo_b);
      end
      rd_idx(3'd3);
      total++;
      if (rdo_a !== 32'd2 || rdo_b !== 32'd2) begin
         bad++; $display("FAIL rw_no_clear a=%h b=%h exp=2", rdo_a, rdo_b);
      end
   endtask

   task automatic test_mask_and_async_reset();
      do_reset();
      pulse(0, 3);
      rd_idx(3'd0);
      total++;
      if (rdo_a !== 32'd3 || rdo_b !== 32'd3) begin
         bad++; $display("FAIL mask_read1 a=%h b=%h exp=3", rdo_a, rdo_b);
      end
      rd_idx(3'd0);
      total++;
      if (rdo_a !== 32'd0 || rdo_b !== 32'd3) begin
         bad++; $display("FAIL mask_read2 a=%h exp=0 b=%h exp=3", rdo_a, rdo_b);
      end
      wr_idx(3'd5, 32'h1);
      total++;
      if (irq_a !== 1'b1 || irq_b !== 1'b1) begin
         bad++; $display("FAIL pre_reset_irq a=%b b=%b exp=1", irq_a, irq_b);
      end
      pulse(0, 1);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (rdo_a !== 32'h0 || rdo_b !== 32'h0 || irq_a !== 1'b0 || irq_b !== 1'b0) begin
         bad++; $display("FAIL async_reset a=%h b=%h irq=%b%b exp=0", rdo_a, rdo_b, irq_a, irq_b);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rd_idx(3'(i));
         total++;
         if (rdo_a !== 32'h0 || rdo_b !== 32'h0) begin
            bad++; $display("FAIL post_reset idx=%0d a=%h b=%h exp=0", i, rdo_a, rdo_b);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] e;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         e = 4'($urandom) & 4'($urandom);
         step(($urandom % 4) != 0, $urandom_range(0, 1) == 1, ($urandom % 4) == 0,
              3'($urandom_range(0, 7)), $urandom, e);
         total++;
         if (rdo_a !== m_rd[0] || irq_a !== m_irq[0]) begin
            bad++; $display("FAIL random_a cyc=%0d rd=%h irq=%b exp rd=%h irq=%b", i, rdo_a, irq_a, m_rd[0], m_irq[0]);
         end
         total++;
         if (rdo_b !== m_rd[1] || irq_b !== m_irq[1]) begin
            bad++; $display("FAIL random_b cyc=%0d rd=%h irq=%b exp rd=%h irq=%b", i, rdo_b, irq_b, m_rd[1], m_irq[1]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      sel = 0; rd = 0; wr = 0; addr = 0; wdata = 0; evt = 0;
      test_reset();
      test_count();
      test_saturate();
      test_event_in_read();
      test_irq();
      test_rw_collision();
      test_mask_and_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
